// File: rtl/sdram_minmax_master.sv
`default_nettype none
// ============================================================================
// Module   : sdram_minmax_master
// Purpose  : Avalon-MM read master that scans NUM_WORDS 16-bit words from
//            SDRAM and reports their unsigned maximum and minimum.
// Revision : 1.0  initial release
// ============================================================================
module sdram_minmax_master #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned NUM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] avm_address,
   output logic        avm_read,
   input  logic [15:0] avm_readdata,
   input  logic        avm_waitrequest,
   input  logic        avm_readdatavalid,
   input  logic        ready_in,
   output logic        done_out,
   output logic [15:0] max_out,
   output logic [15:0] min_out
);

   localparam logic [15:0] c_last_idx = 16'(NUM_WORDS - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] idx_q,   idx_d;
   logic [31:0] addr_q,  addr_d;
   logic        read_q,  read_d;
   logic        done_q,  done_d;
   logic [15:0] max_q,   max_d;
   logic [15:0] min_q,   min_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         idx_q   <= 16'd0;
         addr_q  <= BASE_ADDR;
         read_q  <= 1'b0;
         done_q  <= 1'b0;
         max_q   <= 16'h0000;
         min_q   <= 16'hFFFF;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         read_q  <= read_d;
         done_q  <= done_d;
         max_q   <= max_d;
         min_q   <= min_d;
      end
   end

   // Outputs are all registered; next values are computed one edge ahead
   // so avm_read is already high in the first READ cycle.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      addr_d  = addr_q;
      read_d  = read_q;
      done_d  = done_q;
      max_d   = max_q;
      min_d   = min_q;
      unique case (state_q)
         ST_IDLE: begin
            read_d = 1'b0;
            done_d = 1'b0;
            if (ready_in) begin
               idx_d   = 16'd0;
               addr_d  = BASE_ADDR;
               max_d   = 16'h0000;
               min_d   = 16'hFFFF;
               read_d  = 1'b1;
               state_d = ST_READ;
            end
         end
         ST_READ: begin
            if (!avm_waitrequest) begin
               read_d  = 1'b0;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (avm_readdatavalid) begin
               if (avm_readdata > max_q) max_d = avm_readdata;
               if (avm_readdata < min_q) min_d = avm_readdata;
               if (idx_q == c_last_idx) begin
                  done_d  = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  idx_d   = idx_q + 16'd1;
                  addr_d  = addr_q + 32'd2;
                  read_d  = 1'b1;
                  state_d = ST_READ;
               end
            end
         end
         ST_DONE: begin
            if (!ready_in) begin
               done_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign avm_address = addr_q;
   assign avm_read    = read_q;
   assign done_out    = done_q;
   assign max_out     = max_q;
   assign min_out     = min_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_minmax_master.sv
`default_nettype none
// Testbench for sdram_minmax_master: randomized Avalon slave with a word-level
// reference model, plus small fixed-data instances with literal expectations.
module tb_sdram_minmax_master;

   localparam logic [31:0] MBASE = 32'hFFFF_FC00;
   localparam int          MN    = 1024;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // ---------------- main instance (random slave + model) ----------------
   logic [31:0] m_addr;
   logic        m_read, m_done;
   logic [15:0] m_max, m_min;
   logic [15:0] m_rdata = 16'h0;
   logic        m_wr    = 1'b0;
   logic        m_valid = 1'b0;
   logic        m_ready = 1'b0;
   logic [15:0] mem [MN];

   sdram_minmax_master #(.BASE_ADDR(MBASE), .NUM_WORDS(MN)) u_dut (
      .clk(clk), .reset(reset),
      .avm_address(m_addr), .avm_read(m_read), .avm_readdata(m_rdata),
      .avm_waitrequest(m_wr), .avm_readdatavalid(m_valid),
      .ready_in(m_ready), .done_out(m_done), .max_out(m_max), .min_out(m_min)
   );

   // Reference model: scan phase (0 idle, 1 scanning, 2 done) and the values
   // the outputs must show, updated from what the last rising edge sampled.
   int          phase   = 0;
   int          e_count = 0;
   logic [31:0] e_addr  = MBASE;
   logic        e_read  = 1'b0;
   logic        e_done  = 1'b0;
   logic [15:0] e_max   = 16'h0000;
   logic [15:0] e_min   = 16'hFFFF;
   bit          mon_en  = 0;
   bit          spur_en = 0;
   int          max_stall = 0;
   int          max_lat   = 1;
   int          lat_cnt = 0;
   int          stall   = 0;
   int          pend_idx = 0;
   bit          in_req = 0, accept = 0, stray = 0;
   logic [31:0] req_addr = 32'h0;
   bit          s_reset = 1, s_ready = 0, s_valid = 0, s_real = 0, s_accept = 0;
   logic [15:0] s_data = 16'h0;

   always @(negedge clk) begin
      if (s_reset) begin
         phase = 0; e_count = 0; e_addr = MBASE; e_read = 1'b0; e_done = 1'b0;
         e_max = 16'h0000; e_min = 16'hFFFF;
         in_req = 0; s_accept = 0;
         if (lat_cnt > 0) stray = 1;
      end else if (phase == 0 && s_ready) begin
         phase = 1; e_count = 0; e_addr = MBASE; e_read = 1'b1;
         e_max = 16'h0000; e_min = 16'hFFFF;
      end else if (phase == 1) begin
         if (s_accept) e_read = 1'b0;
         if (s_valid && s_real) begin
            if (s_data > e_max) e_max = s_data;
            if (s_data < e_min) e_min = s_data;
            e_count++;
            if (e_count == MN) begin
               phase = 2; e_done = 1'b1;
            end else begin
               e_addr = e_addr + 32'd2; e_read = 1'b1;
            end
         end
      end else if (phase == 2 && !s_ready) begin
         phase = 0; e_done = 1'b0;
      end

      if (mon_en) begin
         check("avm_address", m_addr, e_addr);
         check("avm_read", m_read, e_read);
         check("done_out", m_done, e_done);
         check("max_out", m_max, e_max);
         check("min_out", m_min, e_min);
      end

      // slave: accepted read gets a random latency; only one may be in flight
      if (s_accept) begin
         check("one_outstanding", lat_cnt, 0);
         lat_cnt  = int'($urandom_range(max_lat, 1));
         pend_idx = int'((req_addr - MBASE) >> 1);
      end
      m_valid = 1'b0;
      s_real  = 0;
      if (lat_cnt > 0) begin
         lat_cnt--;
         if (lat_cnt == 0) begin
            m_valid = 1'b1;
            m_rdata = stray ? 16'h1234 : mem[pend_idx];
            s_real  = !stray;
            stray   = 0;
         end
      end else if (spur_en) begin
         m_valid = 1'($urandom_range(1, 0));
         m_rdata = 16'h1234;
      end
      accept = 0;
      if (m_read) begin
         if (!in_req) begin
            in_req   = 1;
            req_addr = m_addr;
            stall    = int'($urandom_range(max_stall, 0));
         end else begin
            check("addr_stable", m_addr, req_addr);
         end
         if (stall > 0) begin
            m_wr = 1'b1; stall--;
         end else begin
            m_wr = 1'b0; accept = 1; in_req = 0;
         end
      end else begin
         m_wr = spur_en ? 1'($urandom_range(1, 0)) : 1'b0;
      end

      s_reset  = reset;
      s_ready  = m_ready;
      s_valid  = m_valid;
      s_accept = accept;
      s_data   = m_rdata;
   end

   task automatic wait_main_done(input string name);
      int k = 0;
      while (m_done !== 1'b1 && k < 20 * MN) begin
         cycles(1);
         k++;
      end
      check(name, m_done, 1'b1);
   endtask

   // ---------------- small instances, zero wait, 1-cycle latency ----------------
   logic [31:0] a4, a1;
   logic        rd4, rd1, dn4, dn1;
   logic [15:0] mx4, mn4, mx1, mn1;
   logic        v4 = 1'b0, v1 = 1'b0, rdy4 = 1'b0, rdy1 = 1'b0;
   logic [15:0] d4 = 16'h0, d1 = 16'h0;
   logic [15:0] mem4 [4];
   logic [15:0] mem1 = 16'h0;
   logic        acc4 = 1'b0, acc1 = 1'b0;
   logic [1:0]  acc4_idx = 2'd0;
   logic [31:0] log4 [16];
   int          nlog4 = 0;

   sdram_minmax_master #(.BASE_ADDR(32'h0), .NUM_WORDS(4)) u_dut4 (
      .clk(clk), .reset(reset),
      .avm_address(a4), .avm_read(rd4), .avm_readdata(d4),
      .avm_waitrequest(1'b0), .avm_readdatavalid(v4),
      .ready_in(rdy4), .done_out(dn4), .max_out(mx4), .min_out(mn4)
   );

   sdram_minmax_master #(.BASE_ADDR(32'h0), .NUM_WORDS(1)) u_dut1 (
      .clk(clk), .reset(reset),
      .avm_address(a1), .avm_read(rd1), .avm_readdata(d1),
      .avm_waitrequest(1'b0), .avm_readdatavalid(v1),
      .ready_in(rdy1), .done_out(dn1), .max_out(mx1), .min_out(mn1)
   );

   always @(negedge clk) begin
      v4 = acc4;
      d4 = mem4[acc4_idx];
      if (rd4 && nlog4 < 16) begin
         log4[nlog4] = a4;
         nlog4++;
      end
      acc4     = rd4;
      acc4_idx = a4[2:1];
      v1   = acc1;
      d1   = mem1;
      acc1 = rd1;
   end

   // Pulse ready for one cycle and count edges from the start edge to done.
   task automatic run4(output int edges);
      edges = 0;
      rdy4 = 1'b1; cycles(1); rdy4 = 1'b0;
      while (dn4 !== 1'b1 && edges < 40) begin cycles(1); edges++; end
   endtask

   task automatic run1(output int edges);
      edges = 0;
      rdy1 = 1'b1; cycles(1); rdy1 = 1'b0;
      while (dn1 !== 1'b1 && edges < 40) begin cycles(1); edges++; end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int          edges, n0, k;
      logic [15:0] rmax, rmin;

      cycles(3);
      reset  = 1'b0;
      mon_en = 1;
      check("rst_max", m_max, 16'h0000);
      check("rst_min", m_min, 16'hFFFF);
      check("rst_done", m_done, 1'b0);
      check("rst_read", m_read, 1'b0);
      check("rst_addr", m_addr, MBASE);

      // spurious valids while idle
      spur_en = 1; cycles(20); spur_en = 0; cycles(2);
      check("idle_spur_max", m_max, 16'h0000);
      check("idle_spur_min", m_min, 16'hFFFF);
      check("idle_spur_done", m_done, 1'b0);

      // stress scan with stalls and latency, wrapping the address space
      rmax = 16'h0000; rmin = 16'hFFFF;
      for (int i = 0; i < MN; i++) begin
         mem[i] = 16'($urandom);
         if (mem[i] > rmax) rmax = mem[i];
         if (mem[i] < rmin) rmin = mem[i];
      end
      max_stall = 5; max_lat = 4;
      m_ready = 1'b1;
      cycles(1);
      wait_main_done("scan1_done_timeout");
      check("scan1_max", m_max, rmax);
      check("scan1_min", m_min, rmin);

      // hold ready in DONE with spurious valids: no new reads, done held
      spur_en = 1; cycles(10); spur_en = 0; cycles(1);
      check("hold_done", m_done, 1'b1);
      check("hold_max", m_max, rmax);
      m_ready = 1'b0;
      cycles(1);
      check("drop_done", m_done, 1'b0);
      cycles(5);
      check("idle_keep_max", m_max, rmax);
      check("idle_keep_min", m_min, rmin);

      // second scan, ready dropped early, reset mid-scan with a late valid
      for (int i = 0; i < MN; i++) mem[i] = 16'($urandom);
      m_ready = 1'b1; cycles(3); m_ready = 1'b0;
      k = 0;
      while (!(e_count >= 500 && lat_cnt >= 2) && k < 20 * MN) begin cycles(1); k++; end
      check("reset_window_found", 32'(e_count >= 500 && lat_cnt >= 2), 32'd1);
      reset = 1'b1; cycles(1); reset = 1'b0;
      check("midrst_read", m_read, 1'b0);
      check("midrst_addr", m_addr, MBASE);
      check("midrst_max", m_max, 16'h0000);
      check("midrst_min", m_min, 16'hFFFF);
      check("midrst_done", m_done, 1'b0);
      cycles(6);
      check("stray_max", m_max, 16'h0000);
      check("stray_min", m_min, 16'hFFFF);

      // basic 4-word scan
      mem4[0] = 16'h0010; mem4[1] = 16'hFFF0; mem4[2] = 16'h0003; mem4[3] = 16'h8000;
      n0 = nlog4;
      run4(edges);
      check("basic_done_edges", edges, 8);
      check("basic_max", mx4, 16'hFFF0);
      check("basic_min", mn4, 16'h0003);
      cycles(3);
      check("basic_nreads", nlog4 - n0, 4);
      for (int i = 0; i < 4; i++) check("basic_addr", log4[n0 + i], 32'(2 * i));

      // all words 0xFFFF
      for (int i = 0; i < 4; i++) mem4[i] = 16'hFFFF;
      run4(edges);
      check("ffff_done_edges", edges, 8);
      check("ffff_max", mx4, 16'hFFFF);
      check("ffff_min", mn4, 16'hFFFF);

      // single word 0x0000
      mem1 = 16'h0000;
      run1(edges);
      check("one_done_edges", edges, 2);
      check("one_max", mx1, 16'h0000);
      check("one_min", mn1, 16'h0000);
      cycles(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
